set_count_multi: RTL and testbench
==================================

// Module: set_count_multi
// PURPOSE
//  Parametrised successor of the circle-set candidate counter. Takes NUM_CIRC circles
//  (centre x,y plus radius) on a GRID_DIM x GRID_DIM integer grid (coords 1..GRID_DIM).
//  Counts grid points that satisfy a selectable set expression: single, union, XOR,
//  intersection, all-union, exactly-one or at-least-two. Sits behind the same
//  en/busy/valid handshake as the previous generation.
// PARAMETERS
//  NUM_CIRC  3  circles per job, legal 2..4; circle 0 = A, 1 = B, 2 = C, ...
//  COORD_W   4  bits per coordinate and per radius (unsigned)
//  GRID_DIM  8  grid edge length, legal 2..(2**COORD_W)-1
//  CNT_W     derived localparam = $clog2(GRID_DIM*GRID_DIM+1)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst        in   1                   asynchronous reset, active-low
//  en         in   1                   start strobe; sampled only while busy=0
//  central    in   NUM_CIRC*2*COORD_W  circle i: {x,y} at [i*2*COORD_W +: 2*COORD_W], x in upper half
//  radius     in   NUM_CIRC*COORD_W    circle i radius at [i*COORD_W +: COORD_W]
//  mode       in   3                   set expression, latched with en
//  busy       out  1                   job in progress; en ignored while high
//  valid      out  1                   one-cycle result strobe
//  candidate  out  CNT_W               point count, valid when valid=1
// BEHAVIOUR
//  - Reset (rst=0, async): busy=0, valid=0, candidate=0, FSM->IDLE, all latches cleared.
//    Reset mid-scan aborts the job; no valid is produced.
//  - FSM IDLE -> SCAN -> DONE -> IDLE.
//    IDLE: edge with en=1 latches central/radius/mode, clears the accumulator, sets busy=1,
//    moves to SCAN.
//    SCAN: evaluates one point per cycle, raster order x=1..GRID_DIM fastest, then y.
//    After point (GRID_DIM,GRID_DIM) it moves to DONE.
//    DONE: valid=1, candidate=final count, busy still 1 for that cycle.
//    The next edge gives valid=0, busy=0, IDLE.
//  - Latency: valid rises GRID_DIM*GRID_DIM edges after the accepting edge (64 by default).
//    busy falls one edge after valid rises. An en held high across DONE starts nothing
//    until busy=0.
//  - candidate holds its last result until the next accepted en, which clears it to 0.
//  - Inside test for circle i: (px-cx)^2+(py-cy)^2 <= r^2, all as signed COORD_W+1
//    differences, unsigned 2*COORD_W+2 sums, no truncation. Boundary counts as inside.
//  - Edge cases: r=0 gives the centre only. Centres at 0 or outside the grid are legal
//    (purely arithmetic). The count saturates at GRID_DIM^2.
//  - mode: 0 in A; 1 A|B; 2 A^B; 3 AND of all NUM_CIRC; 4 OR of all NUM_CIRC;
//    5 exactly one circle; 6 at least two circles; 7 reserved -> candidate=0 (job still runs).
//  - Inputs other than en are don't-care outside the accepting edge.
// CONFIGURATION
//  ROW_SCAN_EN defined: SCAN evaluates a whole row (GRID_DIM points) per cycle with a
//    GRID_DIM-input popcount adder. Latency = GRID_DIM edges (8 by default). The handshake
//    and all results are identical.
//  ROW_SCAN_EN undefined: one point per cycle as above. Area-minimal default.
// TESTING (defaults NUM_CIRC=3, COORD_W=4, GRID_DIM=8; run with and without ROW_SCAN_EN)
//  1. mode0, A=(4,4) r=2 -> candidate=13. valid exactly 64 edges (8 with ROW_SCAN_EN)
//     after accept; busy low one edge later.
//  2. mode0, A=(1,1) r=1 -> 3. A=(5,5) r=0 -> 1. A=(4,4) r=15 -> 64 (saturation path).
//  3. mode1, A=(2,2) r=1, B=(7,7) r=1 -> 10. mode2 with A=B=(4,4) r=2 -> 0.
//  4. mode3, A=B=C=(4,4) r=2 -> 13. mode5, A=(2,2), B=(7,7), C=(4,4), all r=1 -> 15.
//     mode6 same circles -> 0. mode7 -> 0.
//  5. en held high through a whole job and a second pulse mid-scan -> exactly one valid;
//     the second job starts only after busy=0; candidate is unchanged until then.
//  6. rst low at scan point 30 -> busy/valid/candidate=0 immediately (async). A new job
//     after release -> correct count, no stale valid.

Source files
------------

// File: rtl/set_count_multi.sv
// Circle-set grid point counter: counts points of a GRID_DIM x GRID_DIM grid matching a set expression over NUM_CIRC circles.
// Optional ROW_SCAN_EN evaluates a whole row per cycle instead of one point per cycle.
module set_count_multi #(
  parameter int NUM_CIRC = 3,
  parameter int COORD_W  = 4,
  parameter int GRID_DIM = 8,
  localparam int CNT_W   = $clog2(GRID_DIM*GRID_DIM+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CIRC*2*COORD_W-1:0] central,
  input  logic [NUM_CIRC*COORD_W-1:0]   radius,
  input  logic [2:0]                   mode,
  output logic                         busy,
  output logic                         valid,
  output logic [CNT_W-1:0]             candidate
);

  localparam int SQ_W = 2*COORD_W+2;
  localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(GRID_DIM*GRID_DIM);
  localparam logic [COORD_W-1:0] LAST    = COORD_W'(GRID_DIM);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_next;

  logic [NUM_CIRC*2*COORD_W-1:0] central_q;
  logic [NUM_CIRC*COORD_W-1:0]   radius_q;
  logic [2:0]                    mode_q;
  logic [COORD_W-1:0]            py;
`ifndef ROW_SCAN_EN
  logic [COORD_W-1:0]            px;
`endif
  logic [CNT_W-1:0]              acc, step, acc_next;
  logic [CNT_W:0]                sum;
  logic                          last, accept;

  // Per-circle membership; differences are signed COORD_W+1, squares carried at full width.
  function automatic logic [NUM_CIRC-1:0] inside_vec(
    input logic [COORD_W-1:0]            qx,
    input logic [COORD_W-1:0]            qy,
    input logic [NUM_CIRC*2*COORD_W-1:0] cen,
    input logic [NUM_CIRC*COORD_W-1:0]   rad
  );
    logic [COORD_W-1:0]      cx, cy, r;
    logic signed [COORD_W:0] dx, dy;
    logic signed [SQ_W-1:0]  dxe, dye;
    logic [SQ_W-1:0]         re, d2, r2;
    inside_vec = '0;
    for (int unsigned i = 0; i < NUM_CIRC; i++) begin
      cx  = cen[i*2*COORD_W+COORD_W +: COORD_W];
      cy  = cen[i*2*COORD_W +: COORD_W];
      r   = rad[i*COORD_W +: COORD_W];
      dx  = $signed({1'b0, qx}) - $signed({1'b0, cx});
      dy  = $signed({1'b0, qy}) - $signed({1'b0, cy});
      dxe = SQ_W'(dx);
      dye = SQ_W'(dy);
      re  = SQ_W'(r);
      d2  = $unsigned(dxe * dxe) + $unsigned(dye * dye);
      r2  = re * re;
      inside_vec[i] = (d2 <= r2);
    end
  endfunction

  function automatic logic set_hit(input logic [NUM_CIRC-1:0] v, input logic [2:0] m);
    int unsigned pop;
    pop = 0;
    for (int unsigned i = 0; i < NUM_CIRC; i++)
      if (v[i]) pop++;
    case (m)
      3'd0:    set_hit = v[0];
      3'd1:    set_hit = v[0] | v[1];
      3'd2:    set_hit = v[0] ^ v[1];
      3'd3:    set_hit = &v;
      3'd4:    set_hit = |v;
      3'd5:    set_hit = (pop == 1);
      3'd6:    set_hit = (pop >= 2);
      default: set_hit = 1'b0;
    endcase
  endfunction

  always_comb begin
    step = '0;
`ifdef ROW_SCAN_EN
    for (int unsigned x = 1; x <= GRID_DIM; x++)
      if (set_hit(inside_vec(COORD_W'(x), py, central_q, radius_q), mode_q))
        step = step + CNT_W'(1);
    last = (py == LAST);
`else
    if (set_hit(inside_vec(px, py, central_q, radius_q), mode_q))
      step = CNT_W'(1);
    last = (px == LAST) && (py == LAST);
`endif
    sum      = {1'b0, acc} + {1'b0, step};
    acc_next = (sum > {1'b0, MAX_CNT}) ? MAX_CNT : sum[CNT_W-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SCAN;
      SCAN:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  assign accept = (state == IDLE) && en;
  assign busy   = (state != IDLE);
  assign valid  = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      py        <= '0;
`ifndef ROW_SCAN_EN
      px        <= '0;
`endif
      acc       <= '0;
      candidate <= '0;
    end else if (accept) begin
      central_q <= central;
      radius_q  <= radius;
      mode_q    <= mode;
      py        <= COORD_W'(1);
`ifndef ROW_SCAN_EN
      px        <= COORD_W'(1);
`endif
      acc       <= '0;
      candidate <= '0;
    end else if (state == SCAN) begin
      acc <= acc_next;
      if (last) candidate <= acc_next;
`ifdef ROW_SCAN_EN
      if (!last) py <= py + COORD_W'(1);
`else
      if (px == LAST) begin
        px <= COORD_W'(1);
        if (!last) py <= py + COORD_W'(1);
      end else begin
        px <= px + COORD_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_set_count_multi.sv
// Directed self-checking bench for set_count_multi at default parameters (point or row scan).
module tb_set_count_multi;

  localparam int CNT_W = 7;
`ifdef ROW_SCAN_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 64;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [23:0]      central = '0;
  logic [11:0]      radius = '0;
  logic [2:0]       mode = '0;
  logic             busy, valid;
  logic [CNT_W-1:0] candidate;

  int passed = 0;
  int total  = 0;

  set_count_multi #(.NUM_CIRC(3), .COORD_W(4), .GRID_DIM(8)) dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
  );

  always #5 clk = ~clk;

  // Drives one job and reports what was observed; callers do the comparisons.
  task automatic run_job(
    input  logic [3:0] ax, ay, ar, bx, by, br, cx, cy, cr,
    input  logic [2:0] m,
    output int lat, output logic [CNT_W-1:0] res,
    output logic busy_at_valid, output logic clr_on_accept, output logic idle_after
  );
    @(negedge clk);
    central = {cx, cy, bx, by, ax, ay};
    radius  = {cr, br, ar};
    mode    = m;
    en      = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    clr_on_accept = (candidate === '0) && (busy === 1'b1);
    lat = -1;
    for (int e = 1; e <= LAT + 4; e++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin lat = e; break; end
    end
    res = candidate;
    busy_at_valid = busy;
    @(posedge clk); #1;
    idle_after = (busy === 1'b0) && (valid === 1'b0);
  endtask

  task automatic test_reset;
    #2;
    total++; if ({busy, valid, candidate} !== '0) $display("FAIL reset_outputs got busy=%b valid=%b cand=%0d want 0/0/0", busy, valid, candidate); else passed++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_idle busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_single;
    int lat; logic [CNT_W-1:0] res; logic bav, clr, idl;
    run_job(4'd4, 4'd4, 4'd2, 4'd1, 4'd1, 4'd5, 4'd8, 4'd8, 4'd3, 3'd0, lat, res, bav, clr, idl);
    total++; if (lat !== LAT) $display("FAIL latency got %0d want %0d", lat, LAT); else passed++;
    total++; if (res !== 7'd13) $display("FAIL m0_44_r2 got %0d want 13", res); else passed++;
    total++; if (bav !== 1'b1) $display("FAIL busy_at_valid got %b want 1", bav); else passed++;
    total++; if (idl !== 1'b1) $display("FAIL idle_after_valid got %b want 1", idl); else passed++;
    run_job(4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, lat, res, bav, clr, idl);
    total++; if (clr !== 1'b1) $display("FAIL clear_on_accept got %b want 1", clr); else passed++;
    total++; if (res !== 7'd3) $display("FAIL m0_11_r1 got %0d want 3", res); else passed++;
    run_job(4'd5, 4'd5, 4'd0, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 3'd0, lat, res, bav, clr, idl);
    total++; if (res !== 7'd1) $display("FAIL m0_r0 got %0d want 1", res); else passed++;
    run_job(4'd4, 4'd4, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, lat, res, bav, clr, idl);
    total++; if (res !== 7'd64) $display("FAIL m0_saturate got %0d want 64", res); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (candidate !== 7'd64) $display("FAIL cand_hold got %0d want 64", candidate); else passed++;
  endtask

  task automatic test_sets;
    int lat; logic [CNT_W-1:0] res; logic bav, clr, idl;
    run_job(4'd2, 4'd2, 4'd1, 4'd7, 4'd7, 4'd1, 4'd4, 4'd4, 4'd3, 3'd1, lat, res, bav, clr, idl);
    total++; if (res !== 7'd10) $display("FAIL m1_union got %0d want 10", res); else passed++;
    run_job(4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 4'd1, 4'd1, 4'd1, 3'd2, lat, res, bav, clr, idl);
    total++; if (res !== 7'd0) $display("FAIL m2_xor_same got %0d want 0", res); else passed++;
    run_job(4'd4, 4'd4, 4'd2, 4'd5, 4'd4, 4'd0, 4'd1, 4'd1, 4'd1, 3'd2, lat, res, bav, clr, idl);
    total++; if (res !== 7'd12) $display("FAIL m2_xor_pt got %0d want 12", res); else passed++;
    run_job(4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 3'd3, lat, res, bav, clr, idl);
    total++; if (res !== 7'd13) $display("FAIL m3_and got %0d want 13", res); else passed++;
    run_job(4'd2, 4'd2, 4'd1, 4'd7, 4'd7, 4'd1, 4'd4, 4'd4, 4'd1, 3'd4, lat, res, bav, clr, idl);
    total++; if (res !== 7'd15) $display("FAIL m4_or_all got %0d want 15", res); else passed++;
    run_job(4'd2, 4'd2, 4'd1, 4'd7, 4'd7, 4'd1, 4'd4, 4'd4, 4'd1, 3'd5, lat, res, bav, clr, idl);
    total++; if (res !== 7'd15) $display("FAIL m5_exactly1 got %0d want 15", res); else passed++;
    run_job(4'd2, 4'd2, 4'd1, 4'd7, 4'd7, 4'd1, 4'd4, 4'd4, 4'd1, 3'd6, lat, res, bav, clr, idl);
    total++; if (res !== 7'd0) $display("FAIL m6_disjoint got %0d want 0", res); else passed++;
    run_job(4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd1, 3'd6, lat, res, bav, clr, idl);
    total++; if (res !== 7'd13) $display("FAIL m6_overlap got %0d want 13", res); else passed++;
    run_job(4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 3'd7, lat, res, bav, clr, idl);
    total++; if (res !== 7'd0) $display("FAIL m7_reserved got %0d want 0", res); else passed++;
    total++; if (lat !== LAT) $display("FAIL m7_latency got %0d want %0d", lat, LAT); else passed++;
  endtask

  task automatic test_back_to_back;
    int nvalid = 0; int vedge = -1; int lat2 = -1;
    @(negedge clk);
    central = {8'h00, 8'h00, 8'h44}; radius = {4'd0, 4'd0, 4'd2}; mode = 3'd0; en = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin central = {8'h00, 8'h00, 8'h55}; radius = {4'd0, 4'd0, 4'd0}; end
      if (valid === 1'b1) begin nvalid++; vedge = e; end
    end
    total++; if (nvalid !== 1) $display("FAIL hold_one_valid got %0d want 1", nvalid); else passed++;
    total++; if (vedge !== LAT) $display("FAIL hold_latency got %0d want %0d", vedge, LAT); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL hold_busy_low got %b want 0", busy); else passed++;
    total++; if (candidate !== 7'd13) $display("FAIL hold_cand got %0d want 13", candidate); else passed++;
    @(posedge clk); #1;
    en = 1'b0;
    total++; if (busy !== 1'b1 || candidate !== 7'd0) $display("FAIL second_accept got busy=%b cand=%0d want 1/0", busy, candidate); else passed++;
    for (int e = 1; e <= LAT + 4; e++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin lat2 = e; break; end
    end
    total++; if (lat2 !== LAT || candidate !== 7'd1) $display("FAIL second_job got lat=%0d cand=%0d want %0d/1", lat2, candidate, LAT); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midscan;
    int lat; logic [CNT_W-1:0] res; logic bav, clr, idl;
    int stale = 0;
    @(negedge clk);
    central = {8'h00, 8'h00, 8'h44}; radius = {4'd0, 4'd0, 4'd2}; mode = 3'd0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat ((LAT > 30) ? 30 : LAT / 2) @(posedge clk);
    #2; rst = 1'b0; #1;
    total++; if ({busy, valid, candidate} !== '0) $display("FAIL async_reset got busy=%b valid=%b cand=%0d want 0/0/0", busy, valid, candidate); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    for (int e = 0; e < LAT + 2; e++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    total++; if (stale !== 0) $display("FAIL no_stale_valid got %0d bad cycles want 0", stale); else passed++;
    run_job(4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, lat, res, bav, clr, idl);
    total++; if (lat !== LAT || res !== 7'd3) $display("FAIL post_reset_job got lat=%0d cand=%0d want %0d/3", lat, res, LAT); else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_sets;
    test_back_to_back;
    test_reset_midscan;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
